// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: FSM states, access sizes,
// write payload and alignment/strobe functions.
package lsu_pkg;

   localparam int unsigned DATA_W = 64;
   localparam int unsigned STRB_W = DATA_W / 8;
   localparam int unsigned OFF_W  = 3;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2,
      ST_RESP = 2'd3
   } lsu_state_e;

   typedef enum logic [1:0] {
      SZ_BYTE   = 2'd0,
      SZ_HALF   = 2'd1,
      SZ_WORD   = 2'd2,
      SZ_DOUBLE = 2'd3
   } lsu_size_e;

   typedef struct packed {
      logic              we;
      logic [STRB_W-1:0] wmask;
      logic [DATA_W-1:0] wdata;
   } lsu_wr_t;

   // Natural alignment: the offset bits covered by the access size must be zero
   function automatic logic is_misaligned(lsu_size_e sz, logic [OFF_W-1:0] off);
      logic mis;
      case (sz)
         SZ_BYTE:   mis = 1'b0;
         SZ_HALF:   mis = off[0];
         SZ_WORD:   mis = |off[1:0];
         default:   mis = |off;
      endcase
      return mis;
   endfunction

   function automatic logic [STRB_W-1:0] size_mask(lsu_size_e sz);
      logic [STRB_W-1:0] m;
      case (sz)
         SZ_BYTE:   m = 8'h01;
         SZ_HALF:   m = 8'h03;
         SZ_WORD:   m = 8'h0F;
         default:   m = 8'hFF;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/lsu_ext.sv
// Load lane selection and sign/zero extension of an aligned 8-byte beat.
module lsu_ext
   import lsu_pkg::*;
(
   input  logic [DATA_W-1:0] rdata_i,
   input  logic [OFF_W-1:0]  off_i,
   input  lsu_size_e         size_i,
   input  logic              unsigned_i,
   output logic [DATA_W-1:0] data_o
);

   logic [DATA_W-1:0] lane;

   always_comb begin
      lane   = rdata_i >> {off_i, 3'b000};
      data_o = lane;
      case (size_i)
         SZ_BYTE: data_o = unsigned_i ? {{(DATA_W-8){1'b0}}, lane[7:0]}
                                      : {{(DATA_W-8){lane[7]}}, lane[7:0]};
         SZ_HALF: data_o = unsigned_i ? {{(DATA_W-16){1'b0}}, lane[15:0]}
                                      : {{(DATA_W-16){lane[15]}}, lane[15:0]};
         SZ_WORD: data_o = unsigned_i ? {{(DATA_W-32){1'b0}}, lane[31:0]}
                                      : {{(DATA_W-32){lane[31]}}, lane[31:0]};
         default: data_o = lane;
      endcase
   end

endmodule

// File: rtl/lsu.sv
// Load/store unit: accepts one memory operation at a time from execute, drives an
// aligned 8-byte memory port and returns a one-cycle completion to writeback.
module lsu
   import lsu_pkg::*;
#(
   parameter int unsigned ADDR_W = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid_i,
   output logic              req_ready_o,
   input  logic              req_we_i,
   input  logic [1:0]        req_size_i,
   input  logic              req_unsigned_i,
   input  logic [ADDR_W-1:0] req_addr_i,
   input  logic [DATA_W-1:0] req_wdata_i,
   output logic              mem_req_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   output logic [STRB_W-1:0] mem_wmask_o,
   input  logic              mem_gnt_i,
   input  logic              mem_rvalid_i,
   input  logic [DATA_W-1:0] mem_rdata_i,
   output logic              resp_valid_o,
   output logic [DATA_W-1:0] resp_rdata_o,
   output logic              resp_misalign_o,
   output logic              busy_o
);

   lsu_state_e        state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [OFF_W-1:0]  off_q, off_d;
   lsu_size_e         size_q, size_d;
   logic              uns_q, uns_d;
   lsu_wr_t           wr_q, wr_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              mis_q, mis_d;
   logic              ready_q, ready_d;
   logic              mem_req_q, mem_req_d;
   logic              resp_valid_q, resp_valid_d;
   logic              busy_q, busy_d;

   lsu_size_e         req_size;
   logic [OFF_W-1:0]  req_off;
   logic              req_mis;
   logic              req_st;
   logic [DATA_W-1:0] ext_data;

   lsu_ext u_ext (
      .rdata_i    (mem_rdata_i),
      .off_i      (off_q),
      .size_i     (size_q),
      .unsigned_i (uns_q),
      .data_o     (ext_data)
   );

   // Next state, latched request fields and registered output flags
   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      off_d    = off_q;
      size_d   = size_q;
      uns_d    = uns_q;
      wr_d     = wr_q;
      rdata_d  = rdata_q;
      mis_d    = mis_q;
      req_size = lsu_size_e'(req_size_i);
      req_off  = req_addr_i[OFF_W-1:0];
      req_mis  = is_misaligned(req_size, req_off);
      req_st   = req_we_i && !req_mis;

      case (state_q)
         ST_IDLE: begin
            if (req_valid_i && ready_q) begin
               addr_d   = {req_addr_i[ADDR_W-1:OFF_W], OFF_W'(0)};
               off_d    = req_off;
               size_d   = req_size;
               uns_d    = req_unsigned_i;
               rdata_d  = '0;
               mis_d    = req_mis;
               wr_d.we  = req_st;
               wr_d.wmask = req_st ? STRB_W'(size_mask(req_size) << req_off) : '0;
               wr_d.wdata = req_st ? (req_wdata_i << {req_off, 3'b000}) : '0;
               state_d  = req_mis ? ST_RESP : ST_REQ;
            end
         end
         ST_REQ: begin
            if (mem_gnt_i) begin
               state_d = wr_q.we ? ST_RESP : ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (mem_rvalid_i) begin
               rdata_d = ext_data;
               state_d = ST_RESP;
            end
         end
         ST_RESP: begin
            mis_d   = 1'b0;
            wr_d    = '0;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      ready_d      = (state_d == ST_IDLE);
      mem_req_d    = (state_d == ST_REQ);
      resp_valid_d = (state_d == ST_RESP);
      busy_d       = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= ST_IDLE;
         addr_q       <= '0;
         off_q        <= '0;
         size_q       <= SZ_BYTE;
         uns_q        <= 1'b0;
         wr_q         <= '0;
         rdata_q      <= '0;
         mis_q        <= 1'b0;
         ready_q      <= 1'b1;
         mem_req_q    <= 1'b0;
         resp_valid_q <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         off_q        <= off_d;
         size_q       <= size_d;
         uns_q        <= uns_d;
         wr_q         <= wr_d;
         rdata_q      <= rdata_d;
         mis_q        <= mis_d;
         ready_q      <= ready_d;
         mem_req_q    <= mem_req_d;
         resp_valid_q <= resp_valid_d;
         busy_q       <= busy_d;
      end
   end

   assign req_ready_o     = ready_q;
   assign mem_req_o       = mem_req_q;
   assign mem_we_o        = wr_q.we;
   assign mem_addr_o      = addr_q;
   assign mem_wdata_o     = wr_q.wdata;
   assign mem_wmask_o     = wr_q.wmask;
   assign resp_valid_o    = resp_valid_q;
   assign resp_rdata_o    = rdata_q;
   assign resp_misalign_o = mis_q;
   assign busy_o          = busy_q;

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: hand-computed loads, stores, misaligned faults,
// memory handshake delays and reset abandonment.
module tb_lsu;
   import lsu_pkg::*;

   localparam int unsigned ADDR_W = 64;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              req_valid_i = 1'b0;
   logic              req_ready_o;
   logic              req_we_i = 1'b0;
   logic [1:0]        req_size_i = 2'd0;
   logic              req_unsigned_i = 1'b0;
   logic [ADDR_W-1:0] req_addr_i = '0;
   logic [63:0]       req_wdata_i = '0;
   logic              mem_req_o;
   logic              mem_we_o;
   logic [ADDR_W-1:0] mem_addr_o;
   logic [63:0]       mem_wdata_o;
   logic [7:0]        mem_wmask_o;
   logic              mem_gnt_i = 1'b0;
   logic              mem_rvalid_i = 1'b0;
   logic [63:0]       mem_rdata_i = '0;
   logic              resp_valid_o;
   logic [63:0]       resp_rdata_o;
   logic              resp_misalign_o;
   logic              busy_o;

   int n_tests = 0;
   int n_fail  = 0;

   // Observations of the last operation
   int          r_lat, r_req_cyc, r_pulses, r_bad;
   logic [63:0] r_res, r_wd, r_addr;
   logic [7:0]  r_wm;
   logic        r_we, r_mis, r_unstable;

   always #5 clk = ~clk;

   lsu #(.ADDR_W(ADDR_W)) dut (
      .clk             (clk),
      .rst             (rst),
      .req_valid_i     (req_valid_i),
      .req_ready_o     (req_ready_o),
      .req_we_i        (req_we_i),
      .req_size_i      (req_size_i),
      .req_unsigned_i  (req_unsigned_i),
      .req_addr_i      (req_addr_i),
      .req_wdata_i     (req_wdata_i),
      .mem_req_o       (mem_req_o),
      .mem_we_o        (mem_we_o),
      .mem_addr_o      (mem_addr_o),
      .mem_wdata_o     (mem_wdata_o),
      .mem_wmask_o     (mem_wmask_o),
      .mem_gnt_i       (mem_gnt_i),
      .mem_rvalid_i    (mem_rvalid_i),
      .mem_rdata_i     (mem_rdata_i),
      .resp_valid_o    (resp_valid_o),
      .resp_rdata_o    (resp_rdata_o),
      .resp_misalign_o (resp_misalign_o),
      .busy_o          (busy_o)
   );

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one request and act as memory for a fixed window after acceptance
   task automatic run_op(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [63:0] addr, input logic [63:0] wdata,
                         input logic [63:0] rdata, input int gnt_dly, input int rv_dly);
      bit granted;
      int wait_cyc;
      granted = 1'b0;
      wait_cyc = 0;
      r_lat = 0; r_req_cyc = 0; r_pulses = 0; r_bad = 0;
      r_res = '0; r_wd = '0; r_addr = '0; r_wm = '0; r_we = 1'b0;
      r_mis = 1'b0; r_unstable = 1'b0;
      req_valid_i = 1'b1; req_we_i = we; req_size_i = sz; req_unsigned_i = uns;
      req_addr_i = addr; req_wdata_i = wdata;
      tick();
      req_valid_i = 1'b0; req_we_i = 1'b0; req_addr_i = '0; req_wdata_i = '0;
      for (int c = 1; c <= 14; c++) begin
         mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
         if (mem_req_o) begin
            r_req_cyc++;
            if (r_req_cyc == 1) begin
               r_wd = mem_wdata_o; r_wm = mem_wmask_o; r_addr = mem_addr_o; r_we = mem_we_o;
            end else if (mem_wdata_o !== r_wd || mem_wmask_o !== r_wm ||
                         mem_addr_o !== r_addr || mem_we_o !== r_we) begin
               r_unstable = 1'b1;
            end
            mem_gnt_i    = (r_req_cyc == gnt_dly + 1);
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = ~rdata;
         end else if (granted && !we) begin
            wait_cyc++;
            if (wait_cyc == rv_dly + 1) begin
               mem_rvalid_i = 1'b1;
               mem_rdata_i  = rdata;
            end
         end
         if (mem_gnt_i) granted = 1'b1;
         if (resp_valid_o) begin
            r_pulses++;
            if (r_pulses == 1) begin
               r_lat = c; r_res = resp_rdata_o; r_mis = resp_misalign_o;
            end
         end
         if ((r_lat == 0 || r_lat == c) && (!busy_o || req_ready_o)) r_bad++;
         tick();
      end
      mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int pulses;
      #2;
      check_eq("rst_busy", 64'(busy_o), 64'd0);
      check_eq("rst_resp_valid", 64'(resp_valid_o), 64'd0);
      tick(); tick();
      rst = 1'b1;
      tick();
      check_eq("rst_ready", 64'(req_ready_o), 64'd1);
      check_eq("rst_mem_req", 64'(mem_req_o), 64'd0);
      check_eq("rst_wmask", 64'(mem_wmask_o), 64'd0);
      check_eq("rst_rdata", resp_rdata_o, 64'd0);
      check_eq("rst_misalign", 64'(resp_misalign_o), 64'd0);

      // LW sign-extended, immediate gnt/rvalid
      run_op(1'b0, 2'd2, 1'b0, 64'h8000_0004, 64'd0, 64'h8000_0001_1234_5678, 0, 0);
      check_eq("lw_lat", 64'(r_lat), 64'd3);
      check_eq("lw_data", r_res, 64'hFFFF_FFFF_8000_0001);
      check_eq("lw_addr", r_addr, 64'h8000_0000);
      check_eq("lw_we", 64'(r_we), 64'd0);
      check_eq("lw_wmask", 64'(r_wm), 64'd0);
      check_eq("lw_pulses", 64'(r_pulses), 64'd1);
      check_eq("lw_busy", 64'(r_bad), 64'd0);

      // LBU
      run_op(1'b0, 2'd0, 1'b1, 64'h8000_0003, 64'd0, 64'h0000_0000_F000_0000, 0, 0);
      check_eq("lbu_data", r_res, 64'h0000_0000_0000_00F0);
      check_eq("lbu_lat", 64'(r_lat), 64'd3);

      // LH sign-extended / LHU / LWU / LB positive
      run_op(1'b0, 2'd1, 1'b0, 64'h8000_0102, 64'd0, 64'h0000_0000_8001_0000, 0, 0);
      check_eq("lh_data", r_res, 64'hFFFF_FFFF_FFFF_8001);
      run_op(1'b0, 2'd1, 1'b1, 64'h8000_0102, 64'd0, 64'h0000_0000_8001_0000, 0, 0);
      check_eq("lhu_data", r_res, 64'h0000_0000_0000_8001);
      run_op(1'b0, 2'd2, 1'b1, 64'h8000_0004, 64'd0, 64'h8000_0001_1234_5678, 0, 0);
      check_eq("lwu_data", r_res, 64'h0000_0000_8000_0001);
      run_op(1'b0, 2'd0, 1'b0, 64'h8000_0007, 64'd0, 64'h7F00_0000_0000_00FF, 0, 0);
      check_eq("lb_data", r_res, 64'h0000_0000_0000_007F);

      // SH lane shift and strobe
      run_op(1'b1, 2'd1, 1'b0, 64'h8000_0006, 64'h0000_0000_0000_BEEF, 64'd0, 0, 0);
      check_eq("sh_wdata", r_wd, 64'hBEEF_0000_0000_0000);
      check_eq("sh_wmask", 64'(r_wm), 64'hC0);
      check_eq("sh_we", 64'(r_we), 64'd1);
      check_eq("sh_lat", 64'(r_lat), 64'd2);
      check_eq("sh_rdata", r_res, 64'd0);

      // SB and SD
      run_op(1'b1, 2'd0, 1'b0, 64'h8000_0005, 64'h0000_0000_0000_00AA, 64'd0, 0, 0);
      check_eq("sb_wdata", r_wd, 64'h0000_AA00_0000_0000);
      check_eq("sb_wmask", 64'(r_wm), 64'h20);
      run_op(1'b1, 2'd3, 1'b0, 64'h8000_0010, 64'h0123_4567_89AB_CDEF, 64'd0, 0, 0);
      check_eq("sd_wdata", r_wd, 64'h0123_4567_89AB_CDEF);
      check_eq("sd_wmask", 64'(r_wm), 64'hFF);
      check_eq("sd_addr", r_addr, 64'h8000_0010);

      // Misaligned SW, LD, LH
      run_op(1'b1, 2'd2, 1'b0, 64'h8000_0002, 64'h1234_5678, 64'd0, 0, 0);
      check_eq("sw_mis_req", 64'(r_req_cyc), 64'd0);
      check_eq("sw_mis_flag", 64'(r_mis), 64'd1);
      check_eq("sw_mis_lat", 64'(r_lat), 64'd1);
      check_eq("sw_mis_pulses", 64'(r_pulses), 64'd1);
      run_op(1'b0, 2'd3, 1'b0, 64'h8000_0004, 64'd0, 64'd0, 0, 0);
      check_eq("ld_mis_flag", 64'(r_mis), 64'd1);
      check_eq("ld_mis_req", 64'(r_req_cyc), 64'd0);
      run_op(1'b0, 2'd1, 1'b0, 64'h8000_0001, 64'd0, 64'd0, 0, 0);
      check_eq("lh_mis_flag", 64'(r_mis), 64'd1);

      // LD with gnt delayed 3 and rvalid delayed 2
      run_op(1'b0, 2'd3, 1'b1, 64'h8000_1008, 64'd0, 64'hDEAD_BEEF_CAFE_F00D, 3, 2);
      check_eq("ld_req_cycles", 64'(r_req_cyc), 64'd4);
      check_eq("ld_stable", 64'(r_unstable), 64'd0);
      check_eq("ld_busy", 64'(r_bad), 64'd0);
      check_eq("ld_pulses", 64'(r_pulses), 64'd1);
      check_eq("ld_lat", 64'(r_lat), 64'd8);
      check_eq("ld_data", r_res, 64'hDEAD_BEEF_CAFE_F00D);
      check_eq("ld_mis_clear", 64'(r_mis), 64'd0);

      // Reset while waiting for load data
      req_valid_i = 1'b1; req_we_i = 1'b0; req_size_i = 2'd3; req_unsigned_i = 1'b0;
      req_addr_i = 64'h8000_2000;
      tick();
      req_valid_i = 1'b0;
      mem_gnt_i = 1'b1;
      tick();
      mem_gnt_i = 1'b0;
      check_eq("wr_in_wait_busy", 64'(busy_o), 64'd1);
      rst = 1'b0;
      #1;
      check_eq("wr_rst_busy", 64'(busy_o), 64'd0);
      check_eq("wr_rst_ready", 64'(req_ready_o), 64'd1);
      check_eq("wr_rst_resp", 64'(resp_valid_o), 64'd0);
      tick();
      rst = 1'b1;
      pulses = 0;
      mem_rvalid_i = 1'b1;
      mem_rdata_i = 64'h1111_2222_3333_4444;
      for (int c = 0; c < 5; c++) begin
         tick();
         if (resp_valid_o || busy_o) pulses++;
      end
      mem_rvalid_i = 1'b0;
      check_eq("wr_no_resp", 64'(pulses), 64'd0);
      check_eq("wr_rdata", resp_rdata_o, 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 Parameter: ADDR_W, default 64, width of the data address from the execute stage.
REQ-002 Parameter: DATA_W, fixed at 64, register/data bus width; no other value SHALL be supported.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 req_valid_i  input  1  execute stage presents a memory operation.
REQ-006 req_ready_o  output  1  lsu accepts a request.
REQ-007 req_we_i  input  1  1=store, 0=load.
REQ-008 req_size_i  input  2  access size: 0=byte, 1=half, 2=word, 3=double.
REQ-009 req_unsigned_i  input  1  zero-extend load data (LBU/LHU/LWU).
REQ-010 req_addr_i  input  ADDR_W  byte address (exu result).
REQ-011 req_wdata_i  input  64  store data (rs2 value).
REQ-012 mem_req_o  output  1  memory request.
REQ-013 mem_we_o  output  1  memory write enable.
REQ-014 mem_addr_o  output  ADDR_W  8-byte-aligned address (req_addr[2:0] forced to 0).
REQ-015 mem_wdata_o  output  64  store data shifted into byte lane.
REQ-016 mem_wmask_o  output  8  byte-lane write strobe.
REQ-017 mem_gnt_i  input  1  memory accepted mem_req_o this cycle.
REQ-018 mem_rvalid_i  input  1  load data valid this cycle.
REQ-019 mem_rdata_i  input  64  aligned 8-byte load data.
REQ-020 resp_valid_o  output  1  one-cycle completion pulse to writeback.
REQ-021 resp_rdata_o  output  64  extended load result; 0 for stores.
REQ-022 resp_misalign_o  output  1  completion is a misaligned-access fault.
REQ-023 busy_o  output  1  hold pc/ifu; high whenever state is not IDLE.

Function
REQ-024 FSM states IDLE, REQ, WAIT, RESP; request fields SHALL be latched on acceptance (req_valid_i && req_ready_o).
REQ-025 req_ready_o SHALL be 1 only in IDLE.
REQ-026 IDLE: aligned accept -> REQ; misaligned accept (half addr[0]!=0, word addr[1:0]!=0, double addr[2:0]!=0) -> RESP with resp_misalign_o=1, no memory access.
REQ-027 REQ: mem_req_o=1 with stable addr/we/wdata/wmask until mem_gnt_i; on gnt load -> WAIT, store -> RESP; no gnt -> stay.
REQ-028 WAIT: mem_req_o=0; on mem_rvalid_i capture mem_rdata_i -> RESP; else stay.
REQ-029 RESP: resp_valid_o=1 for exactly one cycle -> IDLE; no new request accepted in RESP.
REQ-030 Minimum latency: load 3 cycles, store 2 cycles, misaligned 1 cycle from acceptance to resp_valid_o.
REQ-031 Store lane: mem_wdata_o = wdata << (8*addr[2:0]); wmask = {1,3,15,255}[size] << addr[2:0].
REQ-032 Load: select lane by addr[2:0], sign- or zero-extend per size/unsigned to 64 bits; double ignores req_unsigned_i.
REQ-033 mem_wmask_o SHALL be 0 and mem_we_o 0 for loads.
REQ-034 mem_rvalid_i outside WAIT SHALL be ignored.

Reset
REQ-035 rst low SHALL immediately force IDLE; all outputs 0 except req_ready_o=1 after release; latched fields cleared.
REQ-036 Reset mid-operation SHALL abandon the transaction with no resp_valid_o pulse.

Structure
REQ-037 State encoding, size codes (Byte/Half/Word/Double) and DATA_W belong in the shared define file.
REQ-038 One sub-module lsu_ext (combinational lane select + extend) is natural; FSM stays in lsu.

Verification
REQ-039 LW addr 0x80000004, rdata 0x8000000112345678, gnt and rvalid immediate -> resp_rdata 0xFFFFFFFF80000001 three cycles after accept.
REQ-040 LBU addr 0x80000003, rdata 0x00000000F0000000 -> resp_rdata 0x00000000000000F0.
REQ-041 SH addr 0x80000006, wdata 0xBEEF -> mem_wdata 0xBEEF000000000000, wmask 0xC0, resp two cycles after accept.
REQ-042 SW addr 0x80000002 -> no mem_req_o, resp_misalign_o=1 one cycle after accept.
REQ-043 LD with gnt delayed 3 cycles and rvalid delayed 2 -> mem_req_o stable 4 cycles, busy_o high throughout, single resp pulse.
REQ-044 rst asserted while in WAIT -> IDLE immediately, no resp_valid_o, later rvalid ignored.
